// File: rtl/aes_key_sched_if.sv
// rtl/aes_key_sched_if.sv - load/handshake bundle between a key schedule consumer and aes_key_sched
interface aes_key_sched_if;
  logic         start;
  logic         dir;
  logic [127:0] key_in;
  logic         abort;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  modport master (
    output start, dir, key_in, abort, rk_ready,
    input  rk, rk_round, rk_valid, busy, done
  );

  modport slave (
    input  start, dir, key_in, abort, rk_ready,
    output rk, rk_round, rk_valid, busy, done
  );
endinterface

// File: rtl/aes_key_sched.sv
// rtl/aes_key_sched.sv - iterative AES-128 key schedule (forward/reverse); AES_KS_ZEROIZE_EN clears key state on return to IDLE
module aes_sbox (
  input  logic       sub,
  input  logic       inv,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  logic [7:0] fwd_out;
  logic [7:0] inv_out;

  always_comb begin
    fwd_out = gf_inv(din) ^ rotl(gf_inv(din), 1) ^ rotl(gf_inv(din), 2)
            ^ rotl(gf_inv(din), 3) ^ rotl(gf_inv(din), 4) ^ 8'h63;
    inv_out = gf_inv(rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05);
    dout    = !sub ? din : (inv ? inv_out : fwd_out);
  end
endmodule

module aes_key_sched #(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  aes_key_sched_if.slave   ks
);
  generate
    if (NR != 10) begin : g_nr_check
      $error("aes_key_sched supports only NR=10 (AES-128)");
    end
  endgenerate

`ifdef AES_KS_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state, state_nx;
  logic [127:0] rk_q;
  logic [3:0]   round_q;
  logic         dir_q;
  logic         done_q;

  logic         accept;
  logic         terminal;
  logic [31:0]  w0, w1, w2, w3, p1, p2, p3, sbox_in, rot, sub_w;
  logic [7:0]   rcon;
  logic [127:0] next_key;

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign accept   = (state == RUN) && ks.rk_ready;
  assign terminal = dir_q ? (round_q == 4'd0) : (round_q == 4'(NR));

  // Both directions share one SubWord: forward feeds w3, reverse feeds the recovered p3
  assign {w0, w1, w2, w3} = rk_q;
  assign p3      = w3 ^ w2;
  assign p2      = w2 ^ w1;
  assign p1      = w1 ^ w0;
  assign sbox_in = dir_q ? p3 : w3;
  assign rot     = {sbox_in[23:0], sbox_in[31:24]};
  assign rcon    = rcon_of(dir_q ? round_q : round_q + 4'd1);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .sub  (1'b1),
      .inv  (1'b0),
      .din  (rot[8*i +: 8]),
      .dout (sub_w[8*i +: 8])
    );
  end

  always_comb begin
    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    t  = sub_w ^ {rcon, 24'h0};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    next_key = dir_q ? {w0 ^ t, p1, p2, p3} : {n0, n1, n2, w3 ^ n2};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (ks.start && !ks.abort) state_nx = RUN;
      RUN:  if (ks.abort || (accept && terminal)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ks.busy     = (state == RUN);
    ks.rk_valid = (state == RUN);
    ks.rk       = rk_q;
    ks.rk_round = round_q;
    ks.done     = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_q    <= '0;
      round_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (ks.start && !ks.abort) begin
          rk_q    <= ks.key_in;
          round_q <= ks.dir ? 4'(NR) : 4'd0;
          dir_q   <= ks.dir;
        end
      end else if (ks.abort || (accept && terminal)) begin
        done_q <= !ks.abort;
        if (ZEROIZE) begin
          rk_q    <= '0;
          round_q <= '0;
        end
      end else if (accept) begin
        rk_q    <= next_key;
        round_q <= dir_q ? round_q - 4'd1 : round_q + 4'd1;
      end
    end
  end
endmodule
